// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad state encoding, key map and decode helpers
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CANDIDATE,
        ST_PRESSED,
        ST_RELEASING
    } kp_state_t;

    // Entry index is {row, col}; nibble 0 is row0/col0 ("1").
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
        case (v)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] idx;
        idx = {row_idx, col_idx};
        return KEY_MAP[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_debouncer_if.sv
// rtl/keypad_debouncer_if.sv - scanner-to-debouncer key sample and result bundle
interface keypad_debouncer_if;
    logic [3:0] row_q;
    logic [3:0] col_q;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] new_digit;
    logic [3:0] old_digit;
    logic       key_held;

    modport master (
        output row_q, col_q,
        input  key_valid, key_code, new_digit, old_digit, key_held
    );

    modport slave (
        input  row_q, col_q,
        output key_valid, key_code, new_digit, old_digit, key_held
    );
endinterface

// File: rtl/keypad_decode.sv
// rtl/keypad_decode.sv - combinational row/column to hex key decode
module keypad_decode
    import keypad_pkg::*;
(
    input  logic [3:0] row_q,
    input  logic [3:0] col_q,
    output logic [3:0] code,
    output logic       valid
);

    always_comb begin
        valid = $onehot(row_q) && $onehot(col_q);
        code  = key_lookup(onehot_to_idx(row_q), onehot_to_idx(col_q));
    end

endmodule

// File: rtl/keypad_debouncer.sv
// rtl/keypad_debouncer.sv - press/release debouncer with accepted-key history
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    keypad_debouncer_if.slave kp
);

    localparam logic [15:0] DB = 16'(DEBOUNCE_CYCLES);

    kp_state_t   state, state_n;
    logic [15:0] cnt, cnt_n, cnt_inc;
    logic [3:0]  cand, cand_n;
    logic [3:0]  dec_code;
    logic        dec_valid;
    logic        accept;

    logic        key_valid_r, key_held_r;
    logic [3:0]  key_code_r, new_digit_r, old_digit_r;

    keypad_decode u_decode (
        .row_q (kp.row_q),
        .col_q (kp.col_q),
        .code  (dec_code),
        .valid (dec_valid)
    );

    assign cnt_inc = (cnt < DB) ? cnt + 16'd1 : cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (dec_valid) begin
                    cand_n = dec_code;
                    if (DB == 16'd1) begin
                        accept  = 1'b1;
                        state_n = ST_PRESSED;
                    end else begin
                        cnt_n   = 16'd1;
                        state_n = ST_CANDIDATE;
                    end
                end
            end
            ST_CANDIDATE: begin
                if (!dec_valid) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (dec_code != cand) begin
                    cand_n = dec_code;
                    cnt_n  = 16'd1;
                end else if (cnt_inc >= DB) begin
                    accept  = 1'b1;
                    state_n = ST_PRESSED;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_PRESSED: begin
                // key_code_r is the held key; anything else starts release counting
                if (!(dec_valid && dec_code == key_code_r)) begin
                    if (DB == 16'd1) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else begin
                        state_n = ST_RELEASING;
                        cnt_n   = 16'd1;
                    end
                end
            end
            ST_RELEASING: begin
                if (dec_valid && dec_code == key_code_r) begin
                    state_n = ST_PRESSED;
                    cnt_n   = '0;
                end else if (cnt_inc >= DB) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid_r <= 1'b0;
            key_code_r  <= '0;
            new_digit_r <= '0;
            old_digit_r <= '0;
            key_held_r  <= 1'b0;
        end else begin
            key_valid_r <= accept;
            key_held_r  <= (state_n == ST_PRESSED) || (state_n == ST_RELEASING);
            if (accept) begin
                key_code_r  <= dec_code;
                new_digit_r <= dec_code;
                old_digit_r <= new_digit_r;
            end
        end
    end

    assign kp.key_valid = key_valid_r;
    assign kp.key_code  = key_code_r;
    assign kp.new_digit = new_digit_r;
    assign kp.old_digit = old_digit_r;
    assign kp.key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_debouncer.sv
// tb/tb_keypad_debouncer.sv - scoreboard bench for keypad_debouncer against a run-length model
module tb_keypad_debouncer;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_debouncer_if kp_if();

    keypad_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_if)
    );

    typedef struct {
        logic       kv;
        logic       held;
        logic [3:0] code;
        logic [3:0] newd;
        logic [3:0] oldd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   key_map[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    // Model: press accepted after N identical valid samples while not held;
    // release completes after N consecutive samples that are not the held key.
    bit         m_held;
    int         m_held_code, m_run, m_run_code, m_rel;
    logic       m_kv;
    logic [3:0] m_code, m_new, m_old;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tb_decode(input logic [3:0] r, input logic [3:0] c);
        int nr = 0, nc = 0, ri = 0, ci = 0;
        for (int i = 0; i < 4; i++) begin
            if (r[i]) begin nr++; ri = i; end
            if (c[i]) begin nc++; ci = i; end
        end
        if (nr == 1 && nc == 1) return key_map[ri * 4 + ci];
        return -1;
    endfunction

    task automatic model_reset();
        m_held = 0; m_held_code = -1; m_run = 0; m_run_code = -1; m_rel = 0;
        m_kv = 0; m_code = 0; m_new = 0; m_old = 0;
    endtask

    task automatic model_step(input int s);
        m_kv = 0;
        if (!m_held) begin
            if (s >= 0 && m_run > 0 && s == m_run_code) m_run++;
            else if (s >= 0) begin m_run = 1; m_run_code = s; end
            else m_run = 0;
            if (m_run == N) begin
                m_kv = 1; m_old = m_new; m_new = 4'(s); m_code = 4'(s);
                m_held = 1; m_held_code = s; m_run = 0; m_rel = 0;
            end
        end else begin
            if (s == m_held_code) m_rel = 0;
            else begin
                m_rel++;
                if (m_rel == N) begin m_held = 0; m_rel = 0; m_run = 0; end
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_kv"},   {3'b0, kp_if.key_valid}, 4'h0);
        chk({tag, "_code"}, kp_if.key_code,  4'h0);
        chk({tag, "_new"},  kp_if.new_digit, 4'h0);
        chk({tag, "_old"},  kp_if.old_digit, 4'h0);
        chk({tag, "_held"}, {3'b0, kp_if.key_held}, 4'h0);
    endtask

    task automatic cycle(input logic [3:0] r, input logic [3:0] c, input bit do_rst);
        exp_t e;
        @(negedge clk);
        kp_if.row_q = r;
        kp_if.col_q = c;
        if (do_rst) begin
            #1 rst = 1'b1;
            #1 chk_zero("async_rst");
            #2 rst = 1'b0;
            model_reset();
        end
        model_step(tb_decode(r, c));
        e.kv = m_kv; e.held = m_held; e.code = m_code; e.newd = m_new; e.oldd = m_old;
        exp_q.push_back(e);
    endtask

    task automatic key_rc(input int key, output logic [3:0] r, output logic [3:0] c);
        r = 4'h0; c = 4'h0;
        for (int i = 0; i < 16; i++)
            if (key_map[i] == key) begin r = 4'(1 << (i / 4)); c = 4'(1 << (i % 4)); end
    endtask

    task automatic press(input int key, input int n);
        logic [3:0] r, c;
        key_rc(key, r, c);
        for (int i = 0; i < n; i++) cycle(r, c, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'h0, 4'h0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("key_valid", {3'b0, kp_if.key_valid}, {3'b0, e.kv});
                chk("key_held",  {3'b0, kp_if.key_held},  {3'b0, e.held});
                chk("key_code",  kp_if.key_code,  e.code);
                chk("new_digit", kp_if.new_digit, e.newd);
                chk("old_digit", kp_if.old_digit, e.oldd);
            end else if (kp_if.key_valid !== 1'b0) begin
                chk("spurious_valid", {3'b0, kp_if.key_valid}, 4'h0);
            end
        end
    end

    initial begin : driver
        logic [3:0] r, c;
        kp_if.row_q = 4'h0;
        kp_if.col_q = 4'h0;
        model_reset();
        #3 chk_zero("reset");
        #9 rst = 1'b0;

        press(2, 6);  idle(5);
        press(5, 2);  idle(1); press(5, 4); idle(5);
        press(1, 5);  idle(2); press(1, 2); idle(4); press(9, 5); idle(5);
        press(10, 5); press(3, 10); idle(5);
        for (int i = 0; i < 10; i++) cycle(4'b0011, 4'b0001, 1'b0);
        press(7, 3);  key_rc(7, r, c); cycle(r, c, 1'b1); press(7, 5); idle(5);
        press(6, 6);  key_rc(6, r, c); cycle(r, c, 1'b1); press(6, 5); idle(5);

        for (int seg = 0; seg < 250; seg++) begin
            int sel = $urandom_range(0, 9);
            int len = $urandom_range(1, 7);
            if (sel < 6) key_rc($urandom_range(0, 15), r, c);
            else if (sel < 8) begin r = 4'h0; c = 4'h0; end
            else begin r = 4'($urandom); c = 4'($urandom); end
            for (int i = 0; i < len; i++)
                cycle(r, c, ($urandom_range(0, 99) == 0));
        end
        idle(6);

        @(posedge clk);
        #2;
        chk("queue_drained", {3'b0, exp_q.size() == 0}, 4'h1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_debouncer.md
KEYPAD_DEBOUNCER -- requirements
Module: keypad_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive identical samples needed to accept a press or a release (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port row_q, input, 4, registered one-hot row of the key under scan from the upstream scanner; 0 means no key.
REQ-005 SHALL have port col_q, input, 4, registered one-hot column paired with row_q; 0 means no key.
REQ-006 SHALL have port key_valid, output, 1, one-cycle pulse marking a newly accepted key.
REQ-007 SHALL have port key_code, output, 4, hex value of the last accepted key.
REQ-008 SHALL have port new_digit, output, 4, most recent accepted key, for display.
REQ-009 SHALL have port old_digit, output, 4, previous value of new_digit, for display.
REQ-010 SHALL have port key_held, output, 1, high while an accepted key is considered pressed.

Function
REQ-011 SHALL decode a sample as valid only if row_q and col_q are both exactly one-hot; any other pattern is "no key".
REQ-012 SHALL map (row,col) indices 0..3: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D.
REQ-013 SHALL implement states IDLE, CANDIDATE, PRESSED, RELEASING with a 16-bit counter cnt.
REQ-014 IDLE: valid sample -> latch candidate code, cnt=1, go CANDIDATE; if DEBOUNCE_CYCLES=1, accept at that same edge and go PRESSED.
REQ-015 CANDIDATE: same code -> cnt+1; different valid code -> relatch candidate, cnt=1; no key -> IDLE, cnt=0.
REQ-016 Acceptance SHALL occur at the edge that samples the DEBOUNCE_CYCLES-th consecutive identical valid code: key_valid=1 for exactly one cycle, key_code=code, old_digit<=new_digit, new_digit<=code, go PRESSED, cnt=0.
REQ-017 PRESSED: input equal to held code -> stay; any other input (no key, invalid, or a different key) -> cnt=1, go RELEASING.
REQ-018 RELEASING: held code reappears -> PRESSED, cnt=0, no new key_valid; otherwise cnt+1; at the DEBOUNCE_CYCLES-th consecutive non-held sample -> IDLE, cnt=0.
REQ-019 A second key pressed while the first is held SHALL never be accepted until release completes and a fresh debounce passes from IDLE.
REQ-020 key_held SHALL be 1 in PRESSED and RELEASING, 0 otherwise.
REQ-021 cnt SHALL saturate at DEBOUNCE_CYCLES and never wrap.
REQ-022 key_code, new_digit and old_digit SHALL change only at acceptance edges.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-024 rst high SHALL immediately force state=IDLE, cnt=0, key_valid=0, key_code=0, new_digit=0, old_digit=0, key_held=0, regardless of the clock.
REQ-025 Reset asserted mid-debounce or mid-press SHALL discard the candidate; after release a still-held key SHALL need a full DEBOUNCE_CYCLES debounce before acceptance.

Structure
REQ-026 Shared package keypad_pkg SHALL hold the state enum and the 16-entry key-map constant, reused by the scanner side.
REQ-027 Sub-module keypad_decode SHALL be combinational: (row_q, col_q) -> (code, valid).

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Hold row_q=0001, col_q=0010 for 6 cycles -> key_valid pulses once on the 4th sampling edge, key_code=2, new_digit=2, old_digit=0, key_held=1.
REQ-029 Bounce: "5" for 2 cycles, 0 for 1 cycle, "5" for 4 cycles -> single key_valid on the 4th edge of the second run, key_code=5.
REQ-030 Press "1" (accepted), release for 2 cycles, re-press "1" -> no second key_valid; release for 4 cycles -> key_held=0; press "9" -> new_digit=9, old_digit=1.
REQ-031 While "A" is held, apply "3" for 10 cycles -> no key_valid, key_held stays high through RELEASING, returns to IDLE after 4 cycles; "3" then accepted only after 4 further edges in CANDIDATE.
REQ-032 row_q=0011, col_q=0001 for 10 cycles -> no key_valid, state stays IDLE.
REQ-033 Assert rst for 3 ns between clock edges during CANDIDATE with cnt=3 -> outputs zero immediately; held key accepted exactly 4 edges after rst drops.
